// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter for one single-port memory
// D has priority, capped by a streak limit while IF waits; a watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_valid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_err,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_valid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);

   localparam int BEW = DATA_WIDTH / 8;
   localparam int SW  = $clog2(MAX_D_STREAK + 1);
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

   state_t          state, state_nx;
   logic [SW-1:0]   streak, streak_nx;
   logic [WDW-1:0]  wd, wd_nx;

   logic                  if_gnt_nx, if_valid_nx, if_err_nx;
   logic                  d_gnt_nx, d_valid_nx, d_err_nx;
   logic [DATA_WIDTH-1:0] if_rdata_nx, d_rdata_nx;
   logic                  mem_req_nx, mem_we_nx;
   logic [BEW-1:0]        mem_be_nx;
   logic [ADDR_WIDTH-1:0] mem_addr_nx;
   logic [DATA_WIDTH-1:0] mem_wdata_nx;
   logic                  busy_nx;
   logic                  arb, done, abort, d_win, if_win;

   always_comb begin
      state_nx     = state;
      streak_nx    = streak;
      wd_nx        = wd;
      if_gnt_nx    = 1'b0;
      d_gnt_nx     = 1'b0;
      if_valid_nx  = 1'b0;
      d_valid_nx   = 1'b0;
      if_rdata_nx  = if_rdata;
      if_err_nx    = if_err;
      d_rdata_nx   = d_rdata;
      d_err_nx     = d_err;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_be_nx    = mem_be;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      arb          = 1'b0;
      done         = 1'b0;
      abort        = 1'b0;
      d_win        = 1'b0;
      if_win       = 1'b0;

      // mem_ready on the expiry cycle still counts as a normal completion
      if (state == IDLE) begin
         arb = 1'b1;
      end else if (mem_ready) begin
         done = 1'b1;
         arb  = 1'b1;
      end else if (TIMEOUT != 0 && wd == WDW'(TIMEOUT)) begin
         abort = 1'b1;
      end else begin
         wd_nx = wd + WDW'(1);
      end

      if (done || abort) begin
         state_nx   = IDLE;
         mem_req_nx = 1'b0;
         if (state == IF_BUSY) begin
            if_valid_nx = 1'b1;
            if_err_nx   = abort;
            if_rdata_nx = done ? mem_rdata : '0;
         end else begin
            d_valid_nx = 1'b1;
            d_err_nx   = abort;
            d_rdata_nx = (done && !mem_we) ? mem_rdata : '0;
         end
      end

      // Arbitration also runs in the completion cycle so the next grant follows with no bubble
      if (arb) begin
         d_win  = d_req && !(if_req && streak == SW'(MAX_D_STREAK));
         if_win = !d_win && if_req;
         if (d_win) begin
            state_nx     = D_BUSY;
            d_gnt_nx     = 1'b1;
            mem_req_nx   = 1'b1;
            mem_we_nx    = d_we;
            mem_be_nx    = d_be;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            wd_nx        = '0;
            streak_nx    = if_req ? streak + SW'(1) : '0;
         end else if (if_win) begin
            state_nx     = IF_BUSY;
            if_gnt_nx    = 1'b1;
            mem_req_nx   = 1'b1;
            mem_we_nx    = 1'b0;
            mem_be_nx    = '0;
            mem_addr_nx  = if_addr;
            mem_wdata_nx = '0;
            wd_nx        = '0;
            streak_nx    = '0;
         end
      end

      if (!if_req) begin
         streak_nx = '0;
      end

      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         wd        <= '0;
         if_gnt    <= 1'b0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         if_err    <= 1'b0;
         d_gnt     <= 1'b0;
         d_valid   <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         streak    <= streak_nx;
         wd        <= wd_nx;
         if_gnt    <= if_gnt_nx;
         if_valid  <= if_valid_nx;
         if_rdata  <= if_rdata_nx;
         if_err    <= if_err_nx;
         d_gnt     <= d_gnt_nx;
         d_valid   <= d_valid_nx;
         d_rdata   <= d_rdata_nx;
         d_err     <= d_err_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_be    <= mem_be_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         busy      <= busy_nx;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_valid, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_gnt, d_valid, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        we;
      logic        err;
   } ev_t;

   ev_t q_ig[$];
   ev_t q_dg[$];
   ev_t q_iv[$];
   ev_t q_dv[$];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got pulse at cycle %0d expected none", name, cyc);
   endtask

   task automatic exp_gnt(input bit is_d, input int t, input logic [31:0] a,
                          input logic we, input logic [3:0] be, input logic [31:0] wd);
      ev_t e;
      e.cyc = t; e.addr = a; e.data = wd; e.be = be; e.we = we; e.err = 1'b0;
      if (is_d) q_dg.push_back(e);
      else      q_ig.push_back(e);
   endtask

   task automatic exp_val(input bit is_d, input int t, input logic [31:0] data, input logic err);
      ev_t e;
      e.cyc = t; e.addr = '0; e.data = data; e.be = '0; e.we = 1'b0; e.err = err;
      if (is_d) q_dv.push_back(e);
      else      q_iv.push_back(e);
   endtask

   // Monitor: pops the expected event whenever the DUT pulses a gnt or valid
   always @(negedge clk) begin
      ev_t e;
      if (if_gnt) begin
         if (q_ig.size() == 0) unexpected("if_gnt");
         else begin
            e = q_ig.pop_front();
            chk("if_gnt cycle", cyc, e.cyc);
            chk("if_gnt addr", mem_addr, e.addr);
            chk("if_gnt wdata", mem_wdata, e.data);
            chk("if_gnt cmd", {26'd0, mem_req, mem_we, mem_be}, {26'd0, 1'b1, e.we, e.be});
         end
      end
      if (d_gnt) begin
         if (q_dg.size() == 0) unexpected("d_gnt");
         else begin
            e = q_dg.pop_front();
            chk("d_gnt cycle", cyc, e.cyc);
            chk("d_gnt addr", mem_addr, e.addr);
            chk("d_gnt wdata", mem_wdata, e.data);
            chk("d_gnt cmd", {26'd0, mem_req, mem_we, mem_be}, {26'd0, 1'b1, e.we, e.be});
         end
      end
      if (if_valid) begin
         if (q_iv.size() == 0) unexpected("if_valid");
         else begin
            e = q_iv.pop_front();
            chk("if_valid cycle", cyc, e.cyc);
            chk("if_rdata", if_rdata, e.data);
            chk("if_err", {31'd0, if_err}, {31'd0, e.err});
         end
      end
      if (d_valid) begin
         if (q_dv.size() == 0) unexpected("d_valid");
         else begin
            e = q_dv.pop_front();
            chk("d_valid cycle", cyc, e.cyc);
            chk("d_rdata", d_rdata, e.data);
            chk("d_err", {31'd0, d_err}, {31'd0, e.err});
         end
      end
   end

   int          mem_wait = 0;
   int          mem_cnt = 0;
   bit          mem_hang = 1'b0;
   bit          idle_ready = 1'b0;
   bit          d_hold = 1'b0;
   logic [31:0] mem_data = '0;

   // One cycle of the memory model and requester handshakes, applied mid-cycle
   task automatic tick();
      @(negedge clk);
      if (if_gnt || d_gnt) begin
         mem_cnt   = mem_wait;
         mem_ready = 1'b0;
      end else if (mem_req && !mem_hang) begin
         if (mem_cnt == 0) mem_ready = 1'b1;
         else begin
            mem_cnt--;
            mem_ready = 1'b0;
         end
      end else begin
         mem_ready = !mem_req && idle_ready;
      end
      mem_rdata = mem_data;
      if (if_gnt) if_req = 1'b0;
      if (d_gnt && !d_hold) d_req = 1'b0;
   endtask

   task automatic run_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic d_issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
      d_we = we; d_addr = a; d_be = be; d_wdata = wd; d_req = 1'b1;
   endtask

   initial begin
      int c;
      repeat (3) tick();
      chk("reset flags", {23'd0, if_gnt, if_valid, if_err, d_gnt, d_valid, d_err, mem_req, mem_we, busy}, 0);
      chk("reset rdata", if_rdata | d_rdata, 0);
      chk("reset mem cmd", mem_addr | mem_wdata | {28'd0, mem_be}, 0);
      rst = 1'b0;
      tick();

      // IF only, zero-wait memory
      c = cyc;
      mem_wait = 0; mem_data = 32'h0000_0013;
      if_addr = 32'h100; if_req = 1'b1;
      exp_gnt(0, c + 1, 32'h100, 1'b0, 4'h0, 32'h0);
      exp_val(0, c + 3, 32'h0000_0013, 1'b0);
      run_until(c + 1);
      chk("t1 busy", {31'd0, busy}, 1);
      run_until(c + 4);
      chk("t1 idle", {30'd0, busy, mem_req}, 0);

      // Simultaneous requests: D first, IF granted in D's completion cycle
      tick();
      c = cyc;
      mem_wait = 3; mem_data = 32'hCAFE_0001;
      if_addr = 32'h200; if_req = 1'b1;
      d_issue(1'b0, 32'h2000, 4'hF, 32'h0);
      exp_gnt(1, c + 1, 32'h2000, 1'b0, 4'hF, 32'h0);
      exp_val(1, c + 6, 32'hCAFE_0001, 1'b0);
      exp_gnt(0, c + 6, 32'h200, 1'b0, 4'h0, 32'h0);
      exp_val(0, c + 11, 32'h0BAD_0002, 1'b0);
      run_until(c + 6);
      mem_data = 32'h0BAD_0002;
      run_until(c + 12);

      // Streak limit: d_req held with IF pending -> 4 D grants, then IF
      c = cyc;
      mem_wait = 0; mem_data = 32'h4444_4444;
      d_hold = 1'b1;
      d_issue(1'b1, 32'h3000, 4'b0011, 32'h1111_1111);
      if_addr = 32'h400; if_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_gnt(1, c + 1 + 2 * k, 32'h3000, 1'b1, 4'b0011, 32'h1111_1111);
         exp_val(1, c + 3 + 2 * k, 32'h0, 1'b0);
      end
      exp_gnt(0, c + 9, 32'h400, 1'b0, 4'h0, 32'h0);
      exp_val(0, c + 11, 32'h4444_4444, 1'b0);
      run_until(c + 9);
      d_hold = 1'b0; d_req = 1'b0;
      run_until(c + 12);
      chk("t3 streak cleared", {29'd0, dut.streak}, 0);

      // Watchdog abort on a hung store
      c = cyc;
      mem_hang = 1'b1;
      d_issue(1'b1, 32'h5000, 4'hF, 32'hDEAD_BEEF);
      exp_gnt(1, c + 1, 32'h5000, 1'b1, 4'hF, 32'hDEAD_BEEF);
      exp_val(1, c + 10, 32'h0, 1'b1);
      run_until(c + 10);
      chk("t4 abort idle", {30'd0, busy, mem_req}, 0);
      mem_hang = 1'b0;
      run_until(c + 11);

      // mem_ready on the exact expiry cycle completes normally
      c = cyc;
      mem_wait = 7; mem_data = 32'h600D_0005;
      d_issue(1'b0, 32'h6000, 4'hF, 32'h0);
      exp_gnt(1, c + 1, 32'h6000, 1'b0, 4'hF, 32'h0);
      exp_val(1, c + 10, 32'h600D_0005, 1'b0);
      run_until(c + 11);

      // mem_ready while idle is ignored
      idle_ready = 1'b1;
      repeat (4) tick();
      idle_ready = 1'b0;
      tick();
      chk("t6 idle ready ignored", {29'd0, if_valid, d_valid, busy}, 0);

      // Asynchronous reset in D_BUSY, then a pending fetch is served
      c = cyc;
      mem_hang = 1'b1; mem_wait = 0;
      d_issue(1'b0, 32'h7000, 4'hF, 32'h0);
      exp_gnt(1, c + 1, 32'h7000, 1'b0, 4'hF, 32'h0);
      run_until(c + 3);
      if_addr = 32'h700; if_req = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("t7 async flags", {23'd0, if_gnt, if_valid, if_err, d_gnt, d_valid, d_err, mem_req, mem_we, busy}, 0);
      chk("t7 async rdata", d_rdata, 0);
      chk("t7 async mem cmd", mem_addr | {28'd0, mem_be}, 0);
      mem_hang = 1'b0; mem_data = 32'h0000_0077;
      tick();
      rst = 1'b0;
      c = cyc;
      exp_gnt(0, c + 1, 32'h700, 1'b0, 4'h0, 32'h0);
      exp_val(0, c + 3, 32'h0000_0077, 1'b0);
      run_until(c + 5);

      chk("q if_gnt drained", q_ig.size(), 0);
      chk("q d_gnt drained", q_dg.size(), 0);
      chk("q if_valid drained", q_iv.size(), 0);
      chk("q d_valid drained", q_dv.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
